// File: rtl/byte_packer_pkg.sv
// Shared constants and types for the byte packer: widths, the message terminator
// and the accumulator state encoding.
package byte_packer_pkg;

    localparam int SYS_DWIDTH_DEF = 8;
    localparam int MST_DWIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CNT_W          = 2;
    localparam int BYTES_W        = 3;

    localparam logic [7:0]         TERMINATOR = 8'hFA;
    localparam logic [CNT_W-1:0]   LAST_CNT   = 2'd3;
    localparam logic [BYTES_W-1:0] FULL_BYTES = 3'd4;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } pk_state_e;

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / packed-word-out bus of the byte packer; the slave side is the packer.
interface byte_packer_if
    import byte_packer_pkg::*;
#(
    parameter int SYS_DWIDTH = SYS_DWIDTH_DEF,
    parameter int MST_DWIDTH = MST_DWIDTH_DEF
);
    logic [SYS_DWIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  busy;
    logic [MST_DWIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  last_o;
    logic [BYTES_W-1:0]    bytes_o;
    logic                  overflow;

    modport slave (
        input  data_i, valid_i, ready_i,
        output busy, data_o, valid_o, last_o, bytes_o, overflow
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  busy, data_o, valid_o, last_o, bytes_o, overflow
    );

endinterface

// File: rtl/byte_packer_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; a push is taken at full only
// when a pop happens on the same edge, so occupancy stays unchanged.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the flags and derive the next occupancy.
    always_comb begin
        do_pop_s  = pop_i & ~empty_q;
        do_push_s = push_i & (~full_q | do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage, power-of-two wrapping pointers and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q   <= occ_d;
            full_q  <= (occ_d == OCC_W'(DEPTH));
            empty_q <= (occ_d == '0);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/byte_packer.sv
// Packs a byte stream MSB-first into words, closing messages on the terminator byte,
// and buffers the packed words with {last, bytes, word} in a small FIFO.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int SYS_DWIDTH = SYS_DWIDTH_DEF,
    parameter int MST_DWIDTH = MST_DWIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    byte_packer_if.slave  bus
);
    localparam int ENTRY_W = MST_DWIDTH + 1 + BYTES_W;

    pk_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MST_DWIDTH-1:0] acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [MST_DWIDTH-1:0] merged_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  is_term_s;
    logic                  full_s;
    logic                  empty_s;
    logic [ENTRY_W-1:0]    push_entry_s;
    logic [ENTRY_W-1:0]    head_entry_s;

    // A full FIFO still takes a byte when the head is popped on the same edge.
    always_comb begin
        pop_s     = bus.ready_i & ~empty_s;
        accept_s  = bus.valid_i & (~full_s | bus.ready_i);
        is_term_s = (bus.data_i == SYS_DWIDTH'(TERMINATOR));
        merged_s  = acc_q;
        merged_s[MST_DWIDTH-1-SYS_DWIDTH*int'(cnt_q) -: SYS_DWIDTH] = bus.data_i;
    end

    // Accumulator next state: store, complete a word, close a message or drop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        push_s       = 1'b0;
        push_entry_s = '0;
        if (bus.valid_i && !accept_s) begin
            ovf_d = 1'b1;
        end else if (accept_s && is_term_s) begin
            push_s       = 1'b1;
            push_entry_s = {1'b1, 1'b0, cnt_q, acc_q};
            state_d      = IDLE;
            cnt_d        = '0;
            acc_d        = '0;
        end else if (accept_s && (cnt_q == LAST_CNT)) begin
            push_s       = 1'b1;
            push_entry_s = {1'b0, FULL_BYTES, merged_s};
            state_d      = IDLE;
            cnt_d        = '0;
            acc_d        = '0;
        end else if (accept_s) begin
            acc_d   = merged_s;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = COLLECT;
        end else begin
            state_d = state_q;
        end
    end

    // Accumulator FSM registers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .data_i  (push_entry_s),
        .pop_i   (pop_s),
        .data_o  (head_entry_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign bus.data_o   = head_entry_s[MST_DWIDTH-1:0];
    assign bus.bytes_o  = head_entry_s[MST_DWIDTH +: BYTES_W];
    assign bus.last_o   = head_entry_s[ENTRY_W-1];
    assign bus.valid_o  = ~empty_s;
    assign bus.busy     = full_s;
    assign bus.overflow = ovf_q;

endmodule
